mem_wb_stage: RTL and testbench

// - MEM/WB pipeline register and load-data formatter; sits directly upstream of the regfile write port.
// - Latches the MEM-stage result, then drives WEN/WADDR/WDATA to the regfile in the WB cycle.
// - Merges the synchronous data-memory read word, which arrives one cycle after MEM.
// - Holds the memory word internally across stalls so WB output stays stable.

---
 rtl/mem_wb_stage.sv | 110 +++++++++++
 tb/tb_mem_wb_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load formatting and a stall hold buffer for the memory word.
// Defining UNALIGNED_LOAD_EN enables LWL/LWR merging.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              MEM_VALID,
  input  logic              MEM_WEN,
  input  logic [ADDR_W-1:0] MEM_WADDR,
  input  logic [DATA_W-1:0] MEM_ALU_RES,
  input  logic              MEM_IS_LOAD,
  input  logic [2:0]        MEM_LD_TYPE,
  input  logic [1:0]        MEM_BYTE_OFF,
  input  logic [DATA_W-1:0] MEM_RT_OLD,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  output logic              WB_VALID,
  output logic              WB_WEN,
  output logic [ADDR_W-1:0] WB_WADDR,
  output logic [DATA_W-1:0] WB_WDATA,
  output logic              WB_ADEL
);
  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4, LWL = 3'd5, LWR = 3'd6;
  logic              v_q, wen_q, ld_q, hold_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] alu_q, hbuf_q, word, wsh, ld_data;
  logic [2:0]        type_q;
  logic [1:0]        off_q;
  logic [7:0]        b;
  logic [15:0]       h;
  logic              mis;
`ifdef UNALIGNED_LOAD_EN
  logic [DATA_W-1:0] rt_q;
  logic [4:0]        sl, sr;
  always_ff @(posedge CLK)
    if (RST) rt_q <= '0;
    else if (!FLUSH && !STALL) rt_q <= MEM_RT_OLD;
`else
  logic unused_rt;
  assign unused_rt = ^MEM_RT_OLD;
`endif
  always_ff @(posedge CLK)
    if (RST) begin
      v_q     <= 1'b0;
      wen_q   <= 1'b0;
      ld_q    <= 1'b0;
      waddr_q <= '0;
      alu_q   <= '0;
      type_q  <= '0;
      off_q   <= '0;
      hold_q  <= 1'b0;
      hbuf_q  <= '0;
    end else if (FLUSH) begin
      v_q    <= 1'b0;
      hold_q <= 1'b0;
    end else if (STALL) begin
      // First stalled edge snapshots the word; later edges keep it so WB stays stable
      if (!hold_q) begin
        hold_q <= 1'b1;
        hbuf_q <= DMEM_RDATA;
      end
    end else begin
      v_q     <= MEM_VALID;
      wen_q   <= MEM_WEN;
      ld_q    <= MEM_IS_LOAD;
      waddr_q <= MEM_WADDR;
      alu_q   <= MEM_ALU_RES;
      type_q  <= MEM_LD_TYPE;
      off_q   <= MEM_BYTE_OFF;
      hold_q  <= 1'b0;
    end
  always_comb begin
    word    = hold_q ? hbuf_q : DMEM_RDATA;
    wsh     = word >> {off_q, 3'b000};
    b       = wsh[7:0];
    h       = off_q[1] ? word[31:16] : word[15:0];
    mis     = 1'b0;
    ld_data = word;
`ifdef UNALIGNED_LOAD_EN
    sl = {2'd3 - off_q, 3'b000};
    sr = {off_q, 3'b000};
`endif
    case (type_q)
      LB:  ld_data = {{(DATA_W-8){b[7]}}, b};
      LBU: ld_data = {{(DATA_W-8){1'b0}}, b};
      LH: begin
        ld_data = {{(DATA_W-16){h[15]}}, h};
        mis     = off_q[0];
      end
      LHU: begin
        ld_data = {{(DATA_W-16){1'b0}}, h};
        mis     = off_q[0];
      end
      LW:  mis = |off_q;
`ifdef UNALIGNED_LOAD_EN
      LWL: ld_data = (word << sl) | (rt_q & ((DATA_W'(1) << sl) - DATA_W'(1)));
      LWR: ld_data = wsh | (rt_q & ~({DATA_W{1'b1}} >> sr));
`endif
      default: mis = 1'b1;
    endcase
  end
  assign WB_VALID = v_q;
  assign WB_ADEL  = v_q & ld_q & mis;
  assign WB_WEN   = v_q & wen_q & ~WB_ADEL;
  assign WB_WADDR = waddr_q;
  assign WB_WDATA = ld_q ? ld_data : alu_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage; LWL/LWR expectations follow UNALIGNED_LOAD_EN.
module tb_mem_wb_stage;
  logic        CLK = 1'b0, RST, STALL, FLUSH;
  logic        MEM_VALID, MEM_WEN, MEM_IS_LOAD;
  logic [4:0]  MEM_WADDR;
  logic [31:0] MEM_ALU_RES, MEM_RT_OLD, DMEM_RDATA;
  logic [2:0]  MEM_LD_TYPE;
  logic [1:0]  MEM_BYTE_OFF;
  logic        WB_VALID, WB_WEN, WB_ADEL;
  logic [4:0]  WB_WADDR;
  logic [31:0] WB_WDATA;
  int          n_chk = 0, n_err = 0;
  typedef struct packed {
    logic        v, wen, adel, cd;
    logic [4:0]  wa;
    logic [31:0] d;
  } exp_t;
  exp_t        sbq[$];
  string       tq[$];
  logic [31:0] dq[$];

  mem_wb_stage dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .MEM_VALID(MEM_VALID), .MEM_WEN(MEM_WEN), .MEM_WADDR(MEM_WADDR),
    .MEM_ALU_RES(MEM_ALU_RES), .MEM_IS_LOAD(MEM_IS_LOAD), .MEM_LD_TYPE(MEM_LD_TYPE),
    .MEM_BYTE_OFF(MEM_BYTE_OFF), .MEM_RT_OLD(MEM_RT_OLD), .DMEM_RDATA(DMEM_RDATA),
    .WB_VALID(WB_VALID), .WB_WEN(WB_WEN), .WB_WADDR(WB_WADDR),
    .WB_WDATA(WB_WDATA), .WB_ADEL(WB_ADEL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic v, wen, adel, input logic [4:0] wa, input logic [31:0] d, input logic cd);
    mk = '{v: v, wen: wen, adel: adel, cd: cd, wa: wa, d: d};
  endfunction

  function automatic exp_t model(input logic v, wen, ld, input logic [2:0] ty, input logic [1:0] off,
                                 input logic [4:0] wa, input logic [31:0] alu, rt, d);
    logic [7:0]  by[4];
    logic [7:0]  rb[4];
    logic [15:0] hw;
    logic [31:0] r;
    logic        bad, adel;
    int          o;
    o = int'(off);
    for (int i = 0; i < 4; i++) begin
      by[i] = d[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    r   = alu;
    bad = 1'b0;
    if (ld)
      case (ty)
        3'd0: r = 32'($signed(by[o]));
        3'd1: r = 32'(by[o]);
        3'd2, 3'd3: begin
          hw  = {by[(o & 2) + 1], by[o & 2]};
          bad = off[0];
          r   = (ty == 3'd2) ? 32'($signed(hw)) : 32'(hw);
        end
        3'd4: begin
          r   = d;
          bad = (o != 0);
        end
`ifdef UNALIGNED_LOAD_EN
        3'd5: for (int i = 0; i < 4; i++)
          if (i >= 3 - o) r[8*i +: 8] = by[i - (3 - o)];
          else r[8*i +: 8] = rb[i];
        3'd6: for (int i = 0; i < 4; i++)
          if (i < 4 - o) r[8*i +: 8] = by[i + o];
          else r[8*i +: 8] = rb[i];
`endif
        default: bad = 1'b1;
      endcase
    adel  = v & bad;
    model = mk(v, v & wen & ~adel, adel, wa, r, v & ~adel);
  endfunction

  task automatic cmp;
    exp_t  e;
    string t;
    e = sbq.pop_front();
    t = tq.pop_front();
    check({t, ".valid"}, 32'(WB_VALID), 32'(e.v));
    check({t, ".wen"}, 32'(WB_WEN), 32'(e.wen));
    check({t, ".adel"}, 32'(WB_ADEL), 32'(e.adel));
    if (e.cd) begin
      check({t, ".waddr"}, 32'(WB_WADDR), 32'(e.wa));
      check({t, ".wdata"}, WB_WDATA, e.d);
    end
  endtask

  task automatic expect_next(input string t, input exp_t e);
    sbq.push_back(e);
    tq.push_back(t);
    @(posedge CLK);
    #1 cmp();
  endtask

  task automatic drive(input logic v, wen, ld, input logic [2:0] ty, input logic [1:0] off,
                       input logic [4:0] wa, input logic [31:0] alu, rt);
    MEM_VALID = v; MEM_WEN = wen; MEM_IS_LOAD = ld; MEM_LD_TYPE = ty;
    MEM_BYTE_OFF = off; MEM_WADDR = wa; MEM_ALU_RES = alu; MEM_RT_OLD = rt;
  endtask

  task automatic issue(input string t, input logic v, wen, ld, input logic [2:0] ty, input logic [1:0] off,
                       input logic [4:0] wa, input logic [31:0] alu, rt, d, input exp_t e);
    @(negedge CLK);
    drive(v, wen, ld, ty, off, wa, alu, rt);
    sbq.push_back(e);
    tq.push_back(t);
    dq.push_back(d);
    @(posedge CLK);
    #1 DMEM_RDATA = dq.pop_front();
    #1 cmp();
  endtask

  task automatic issue_m(input string t, input logic v, wen, ld, input logic [2:0] ty, input logic [1:0] off,
                         input logic [4:0] wa, input logic [31:0] alu, rt, d);
    issue(t, v, wen, ld, ty, off, wa, alu, rt, d, model(v, wen, ld, ty, off, wa, alu, rt, d));
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0; DMEM_RDATA = '0;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd3, 32'hFFFF_FFFF, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    sbq.push_back(mk(0, 0, 0, 5'd0, 32'h0, 1)); tq.push_back("reset"); cmp();
    @(negedge CLK) RST = 1'b0;

    issue("alu", 1, 1, 0, 3'd0, 2'd0, 5'd5, 32'h1234_5678, 32'h0, 32'hDEAD_0000, mk(1, 1, 0, 5'd5, 32'h1234_5678, 1));
    issue("lb", 1, 1, 1, 3'd0, 2'd3, 5'd6, 32'h0, 32'h0, 32'h80FF_0000, mk(1, 1, 0, 5'd6, 32'hFFFF_FF80, 1));
    issue("lbu", 1, 1, 1, 3'd1, 2'd3, 5'd6, 32'h0, 32'h0, 32'h80FF_0000, mk(1, 1, 0, 5'd6, 32'h0000_0080, 1));
    issue("lh_mis", 1, 1, 1, 3'd2, 2'd1, 5'd8, 32'h0, 32'h0, 32'h1234_5678, mk(1, 0, 1, 5'd8, 32'h0, 0));
    issue("lhu", 1, 1, 1, 3'd3, 2'd2, 5'd9, 32'h0, 32'h0, 32'h9ABC_0000, mk(1, 1, 0, 5'd9, 32'h0000_9ABC, 1));
    issue("lh_neg", 1, 1, 1, 3'd2, 2'd0, 5'd9, 32'h0, 32'h0, 32'h0000_8001, mk(1, 1, 0, 5'd9, 32'hFFFF_8001, 1));
    issue("lw", 1, 1, 1, 3'd4, 2'd0, 5'd10, 32'h0, 32'h0, 32'hDEAD_BEEF, mk(1, 1, 0, 5'd10, 32'hDEAD_BEEF, 1));
    issue("lw_mis", 1, 1, 1, 3'd4, 2'd2, 5'd10, 32'h0, 32'h0, 32'hDEAD_BEEF, mk(1, 0, 1, 5'd10, 32'h0, 0));
    issue("ty7", 1, 1, 1, 3'd7, 2'd0, 5'd11, 32'h0, 32'h0, 32'h1, mk(1, 0, 1, 5'd11, 32'h0, 0));
`ifdef UNALIGNED_LOAD_EN
    issue("lwl", 1, 1, 1, 3'd5, 2'd1, 5'd12, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, mk(1, 1, 0, 5'd12, 32'h3344_CCDD, 1));
    issue("lwr", 1, 1, 1, 3'd6, 2'd1, 5'd12, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, mk(1, 1, 0, 5'd12, 32'hAA11_2233, 1));
`else
    issue("lwl", 1, 1, 1, 3'd5, 2'd1, 5'd12, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, mk(1, 0, 1, 5'd12, 32'h0, 0));
    issue("lwr", 1, 1, 1, 3'd6, 2'd1, 5'd12, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, mk(1, 0, 1, 5'd12, 32'h0, 0));
`endif
    issue("r0", 1, 1, 0, 3'd0, 2'd0, 5'd0, 32'h0000_00AB, 32'h0, 32'h0, mk(1, 1, 0, 5'd0, 32'h0000_00AB, 1));
    issue("bubble", 0, 1, 0, 3'd0, 2'd0, 5'd4, 32'h1, 32'h0, 32'h0, mk(0, 0, 0, 5'd4, 32'h0, 0));

    // LW held across a 3-cycle stall while the memory bus changes
    issue("lw_st0", 1, 1, 1, 3'd4, 2'd0, 5'd7, 32'h0, 32'h0, 32'hAAAA_AAAA, mk(1, 1, 0, 5'd7, 32'hAAAA_AAAA, 1));
    @(negedge CLK);
    STALL = 1'b1;
    drive(1, 1, 0, 3'd0, 2'd0, 5'd20, 32'h0BAD_0BAD, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1 DMEM_RDATA = 32'h5555_5555;
      sbq.push_back(mk(1, 1, 0, 5'd7, 32'hAAAA_AAAA, 1)); tq.push_back($sformatf("lw_stall%0d", k));
      #1 cmp();
    end
    @(negedge CLK) STALL = 1'b0;
    issue_m("post_stall", 1, 1, 1, 3'd1, 2'd2, 5'd13, 32'h0, 32'h0, 32'h00C3_0000);

    issue("pre_fs", 1, 1, 0, 3'd0, 2'd0, 5'd9, 32'h111, 32'h0, 32'h0, mk(1, 1, 0, 5'd9, 32'h111, 1));
    @(negedge CLK) begin STALL = 1'b1; FLUSH = 1'b1; end
    expect_next("flush_stall", mk(0, 0, 0, 5'd0, 32'h0, 0));
    @(negedge CLK) begin STALL = 1'b0; FLUSH = 1'b0; end

    issue("pre_f", 1, 1, 1, 3'd4, 2'd1, 5'd9, 32'h0, 32'h0, 32'h0, mk(1, 0, 1, 5'd9, 32'h0, 0));
    @(negedge CLK) FLUSH = 1'b1;
    expect_next("flush", mk(0, 0, 0, 5'd0, 32'h0, 0));
    @(negedge CLK) FLUSH = 1'b0;

    issue("pre_rst", 1, 1, 0, 3'd0, 2'd0, 5'd17, 32'hCAFE_F00D, 32'h0, 32'h0, mk(1, 1, 0, 5'd17, 32'hCAFE_F00D, 1));
    @(negedge CLK) STALL = 1'b1;
    expect_next("stall_hold", mk(1, 1, 0, 5'd17, 32'hCAFE_F00D, 1));
    @(negedge CLK) RST = 1'b1;
    expect_next("rst_stall", mk(0, 0, 0, 5'd0, 32'h0, 1));
    @(negedge CLK) begin RST = 1'b0; STALL = 1'b0; end

    for (int i = 0; i < 60; i++)
      issue_m($sformatf("rnd%0d", i), 1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
              3'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
